// File: rtl/cpu_pkg.sv
// Shared types and sizing constants for the instruction-cache fill path.
// The block geometry below matches the default fill controller configuration.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_IDX_W      = 3;
  localparam int ADDR_W          = 16;

endpackage

// File: rtl/fill_word_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
// Used once to count issued reads and once to count returned words.
module fill_word_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  assign done = (count == WIDTH'(TERMINAL));

  // NOTE: registered state is always assigned non-blocking so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss handler: issues one read per block word back-to-back,
// steers returning words into the data array in order, then strobes the tag.
module icache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = cpu_pkg::WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_WIDTH      = cpu_pkg::ADDR_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data_in,
  output logic                               fsm_busy,
  output logic                               memory_read,
  output logic [ADDR_WIDTH-1:0]              memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_idx,
  output logic [15:0]                        cache_data_out,
  output logic                               write_tag_array
);

  import cpu_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_block
    $error("WORDS_PER_BLOCK must be a power of two of at least 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end

  fill_state_t           state, next_state;
  logic                  start;
  logic [CNT_W-1:0]      issue_cnt, return_cnt;
  logic                  issue_done, return_done;
  logic [CNT_W-1:0]      issue_sel;
  logic [ADDR_WIDTH-1:0] base_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state       = state;
    start            = 1'b0;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so a miss seen while reset is held cannot raise the stall.
        fsm_busy = rst_n & miss_detected;
        if (rst_n && miss_detected) begin
          start      = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        fsm_busy    = 1'b1;
        memory_read = !issue_done;
        if (memory_data_valid && !return_done) begin
          write_data_array = 1'b1;
          if (return_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array = 1'b1;
            next_state      = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr <= '0;
    end else if (start) begin
      base_addr <= miss_address & ~OFFSET_MASK;
    end
  end

  fill_word_counter #(.WIDTH(CNT_W), .TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (memory_read),
    .count (issue_cnt),
    .done  (issue_done)
  );

  fill_word_counter #(.WIDTH(CNT_W), .TERMINAL(WORDS_PER_BLOCK)) u_return_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (write_data_array),
    .count (return_cnt),
    .done  (return_done)
  );

  // Once all reads are out the address parks on the last word issued.
  assign issue_sel      = issue_done ? CNT_W'(WORDS_PER_BLOCK - 1) : issue_cnt;
  assign memory_address = base_addr + (ADDR_WIDTH'(issue_sel) << 1);
  assign data_word_idx  = write_data_array ? return_cnt[IDX_W-1:0] : '0;
  assign cache_data_out = write_data_array ? memory_data_in : '0;

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Self-checking bench for icache_fill_fsm: pipelined memory responder, a
// block-fill reference model checked every cycle, and pinned literal timelines.
module tb_icache_fill_fsm;

  localparam int WPB = 8;
  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_word_idx;
  logic [15:0] cache_data_out;
  logic        write_tag_array;

  icache_fill_fsm #(.WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT), .ADDR_WIDTH(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_idx     (data_word_idx),
    .cache_data_out    (cache_data_out),
    .write_tag_array   (write_tag_array)
  );

  typedef struct { int cyc; logic [15:0] addr; } req_t;
  typedef struct { int cyc; int idx; logic [15:0] data; } wr_t;
  typedef struct { int ready; logic [15:0] data; } ret_t;

  req_t        req_log[$];
  wr_t         wr_log[$];
  int          tag_log[$];
  ret_t        mem_q[$];
  bit          busy_hist[int];

  int          cyc;
  int          n_checks;
  int          n_errors;
  logic [15:0] salt;
  bit          gap_mode;
  bit          stray_valid;
  int          gap_left;

  // Reference model: where the current fill stands, in words issued/returned.
  bit          m_fill;
  int          m_iss;
  int          m_ret;
  logic [15:0] m_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    wr_log.delete();
    tag_log.delete();
  endtask

  task automatic start_miss(input logic [15:0] a, output int t0);
    miss_detected = 1'b1;
    miss_address  = a;
    t0            = cyc;
    step();
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
  endtask

  task automatic wait_tag(input int budget);
    int n0;
    int k;
    n0 = tag_log.size();
    k  = 0;
    while (tag_log.size() == n0 && k < budget) begin
      step();
      k++;
    end
    check("tag_within_budget", tag_log.size(), n0 + 1);
  endtask

  task automatic wait_mem_empty(input int budget);
    int k;
    k = 0;
    while (mem_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check("mem_drained", mem_q.size(), 0);
    step();
    step();
  endtask

  // Compare process: every cycle, outputs against the model, then advance the model.
  always @(negedge clk) begin : compare
    bit   e_read, e_wr, e_tag;
    req_t r;
    wr_t  w;
    ret_t m;
    if (!rst_n) begin
      check("rst_busy",  fsm_busy, 0);
      check("rst_read",  memory_read, 0);
      check("rst_addr",  memory_address, 0);
      check("rst_wr",    write_data_array, 0);
      check("rst_idx",   data_word_idx, 0);
      check("rst_data",  cache_data_out, 0);
      check("rst_tag",   write_tag_array, 0);
      m_fill = 1'b0;
      m_iss  = 0;
      m_ret  = 0;
    end else begin
      e_read = m_fill && (m_iss < WPB);
      e_wr   = m_fill && memory_data_valid && (m_ret < WPB);
      e_tag  = e_wr && (m_ret == WPB - 1);
      check("busy", fsm_busy, m_fill || miss_detected);
      check("read", memory_read, e_read);
      check("wr",   write_data_array, e_wr);
      check("tag",  write_tag_array, e_tag);
      if (e_read) check("addr", memory_address, m_base + 16'(2 * m_iss));
      if (e_wr) begin
        check("idx",  data_word_idx, m_ret);
        check("data", cache_data_out, memory_data_in);
      end
      if (!m_fill) begin
        if (miss_detected) begin
          m_fill = 1'b1;
          m_base = miss_address & 16'hFFF0;
          m_iss  = 0;
          m_ret  = 0;
        end
      end else begin
        if (e_read) m_iss++;
        if (e_wr)   m_ret++;
        if (e_tag)  m_fill = 1'b0;
      end
    end
    busy_hist[cyc] = fsm_busy;
    if (memory_read) begin
      r.cyc = cyc; r.addr = memory_address;
      req_log.push_back(r);
      m.ready = cyc + LAT; m.data = salt + 16'(memory_address[3:1]);
      mem_q.push_back(m);
    end
    if (write_data_array) begin
      w.cyc = cyc; w.idx = int'(data_word_idx); w.data = cache_data_out;
      wr_log.push_back(w);
    end
    if (write_tag_array) tag_log.push_back(cyc);
  end

  // Pipelined memory: returns in order LAT cycles after issue, optionally with gaps.
  always @(posedge clk) begin : responder
    #2;
    memory_data_valid = 1'b0;
    memory_data_in    = 16'($urandom);
    if (stray_valid) begin
      memory_data_valid = 1'b1;
      memory_data_in    = 16'hBEEF;
      stray_valid       = 1'b0;
    end else if (mem_q.size() != 0 && mem_q[0].ready <= cyc) begin
      if (gap_left > 0) begin
        gap_left--;
      end else begin
        memory_data_valid = 1'b1;
        memory_data_in    = mem_q[0].data;
        mem_q.delete(0);
        if (gap_mode) gap_left = $urandom_range(0, 3);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int t0;
    int t1;
    int hold;
    int cnt;
    logic [15:0] a;

    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data_in    = 16'h0;
    cyc = 0; n_checks = 0; n_errors = 0;
    salt = 16'hA000; gap_mode = 1'b0; stray_valid = 1'b0; gap_left = 0;
    m_fill = 1'b0; m_iss = 0; m_ret = 0; m_base = 16'h0;

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("post_reset_busy", fsm_busy, 0);
    check("post_reset_read", memory_read, 0);

    // Nominal fill at 0x1234 with fixed latency.
    clear_logs();
    salt = 16'hA000;
    start_miss(16'h1234, t0);
    wait_tag(40);
    step();
    check("t1_req_count", req_log.size(), 8);
    check("t1_wr_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t1_req_cyc",  req_log[i].cyc, t0 + 1 + i);
      check("t1_req_addr", req_log[i].addr, 16'h1230 + 16'(2 * i));
      check("t1_wr_cyc",   wr_log[i].cyc, t0 + 5 + i);
      check("t1_wr_idx",   wr_log[i].idx, i);
      check("t1_wr_data",  wr_log[i].data, 16'hA000 + 16'(i));
    end
    check("t1_tag_cyc", tag_log[0], t0 + 12);
    check("t1_busy_c0", busy_hist[t0], 1);
    check("t1_busy_c12", busy_hist[t0 + 12], 1);
    check("t1_busy_c13", busy_hist[t0 + 13], 0);
    wait_mem_empty(20);

    // Miss held high with another address through the fill: back-to-back fill.
    clear_logs();
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    t0 = cyc;
    step();
    miss_address = 16'h5550;
    repeat (13) step();
    miss_detected = 1'b0;
    wait_tag(40);
    check("t2_first_tag", tag_log[0], t0 + 12);
    check("t2_last_old_addr", req_log[7].addr, 16'h123E);
    check("t2_first_new_addr", req_log[8].addr, 16'h5550);
    check("t2_first_new_cyc", req_log[8].cyc, t0 + 14);
    check("t2_req_count", req_log.size(), 16);
    wait_mem_empty(20);

    // Irregular return gaps.
    clear_logs();
    salt = 16'($urandom);
    gap_mode = 1'b1;
    start_miss(16'($urandom), t0);
    wait_tag(100);
    check("t3_wr_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t3_wr_idx",  wr_log[i].idx, i);
      check("t3_wr_data", wr_log[i].data, salt + 16'(i));
    end
    check("t3_tag_with_last", tag_log[0], wr_log[7].cyc);
    cnt = 0;
    for (int c = t0; c <= tag_log[0]; c++) if (busy_hist[c]) cnt++;
    check("t3_busy_whole_fill", cnt, tag_log[0] - t0 + 1);
    gap_mode = 1'b0;
    gap_left = 0;
    wait_mem_empty(60);

    // Reset at cycle 6 of a fill, with a miss asserted during reset.
    clear_logs();
    start_miss(16'h2468, t0);
    repeat (5) step();
    rst_n = 1'b0;
    miss_detected = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    miss_detected = 1'b0;
    wait_mem_empty(20);
    check("t4_no_tag", tag_log.size(), 0);
    check("t4_wr_before_rst", wr_log.size(), 1);
    cnt = 0;
    foreach (wr_log[i]) if (wr_log[i].cyc >= t0 + 6) cnt++;
    check("t4_no_late_wr", cnt, 0);
    check("t4_busy_in_rst", busy_hist[t0 + 6], 0);

    // Block at the top of the address space, then spurious valids while idle.
    clear_logs();
    salt = 16'($urandom);
    start_miss(16'hFFF8, t0);
    wait_tag(40);
    stray_valid = 1'b1;
    step();
    step();
    step();
    stray_valid = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) check("t5_addr", req_log[i].addr, 16'hFFF0 + 16'(2 * i));
    check("t5_last_addr", req_log[7].addr, 16'hFFFE);
    check("t6_no_extra_wr", wr_log.size(), 8);
    check("t6_one_tag", tag_log.size(), 1);
    wait_mem_empty(20);

    // Randomized fills.
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      salt     = 16'($urandom);
      gap_mode = 1'($urandom_range(0, 1));
      a        = 16'($urandom);
      hold     = $urandom_range(1, 3);
      miss_detected = 1'b1;
      miss_address  = a;
      t1 = cyc;
      repeat (hold) begin
        step();
        miss_address = 16'($urandom);
      end
      miss_detected = 1'b0;
      wait_tag(120);
      check("rnd_first_req_cyc", req_log[0].cyc, t1 + 1);
      for (int i = 0; i < 8; i++) begin
        check("rnd_addr", req_log[i].addr, (a & 16'hFFF0) + 16'(2 * i));
        check("rnd_data", wr_log[i].data, salt + 16'(i));
      end
      gap_mode = 1'b0;
      gap_left = 0;
      wait_mem_empty(60);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
